// File: rtl/reorder_buffer_if.sv
// Reorder buffer handshake bundle: allocation from the renamer,
// completion from the functional units, commit and free-list return.
interface reorder_buffer_if #(
    parameter int ROB_DEPTH    = 16,
    parameter int PRN_BITS     = 6,
    parameter int FU_COUNT     = 4,
    parameter int MAX_OPERANDS = 3
);
    localparam int TAG_BITS = $clog2(ROB_DEPTH);

    logic                                   alloc_valid;
    logic [MAX_OPERANDS-1:0]                alloc_old_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_old_prn;
    logic                                   alloc_ready;
    logic [TAG_BITS-1:0]                    alloc_tag;
    logic [FU_COUNT-1:0]                    complete_valid;
    logic [FU_COUNT-1:0][TAG_BITS-1:0]      complete_tag;
    logic                                   commit_valid;
    logic [TAG_BITS-1:0]                    commit_tag;
    logic [MAX_OPERANDS-1:0]                free_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns;
    logic [TAG_BITS:0]                      count;

    modport master (
        output alloc_valid, alloc_old_valid, alloc_old_prn,
        output complete_valid, complete_tag,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag,
        input  free_valid, free_prns, count
    );

    modport slave (
        input  alloc_valid, alloc_old_valid, alloc_old_prn,
        input  complete_valid, complete_tag,
        output alloc_ready, alloc_tag, commit_valid, commit_tag,
        output free_valid, free_prns, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer returning superseded PRNs to the free list.
// Optional macro ROB_PERF_COUNT_EN adds a 32-bit perf_commits counter.
module reorder_buffer #(
    parameter int ROB_DEPTH    = 16,
    parameter int PRN_BITS     = 6,
    parameter int FU_COUNT     = 4,
    parameter int MAX_OPERANDS = 3
) (
    input  logic              clk,
    input  logic              rst,
    reorder_buffer_if.slave   bus
`ifdef ROB_PERF_COUNT_EN
    ,
    output logic [31:0]       perf_commits
`endif
);
    localparam int TAG_BITS = $clog2(ROB_DEPTH);
    localparam logic [TAG_BITS:0] DEPTH_C = (TAG_BITS+1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]                   valid_q;
    logic [ROB_DEPTH-1:0]                   done_q;
    logic [MAX_OPERANDS-1:0]                old_valid_q [ROB_DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  old_prn_q   [ROB_DEPTH];
    logic [TAG_BITS-1:0]                    head_q;
    logic [TAG_BITS-1:0]                    tail_q;
    logic [TAG_BITS:0]                      count_q;
    logic                                   alloc_fire;
    logic                                   commit;

    assign bus.alloc_ready  = (count_q < DEPTH_C);
    assign bus.alloc_tag    = tail_q;
    assign bus.count        = count_q;
    assign alloc_fire       = bus.alloc_valid && bus.alloc_ready;
    assign commit           = valid_q[head_q] && done_q[head_q];
    assign bus.commit_valid = commit;
    assign bus.commit_tag   = head_q;
    assign bus.free_valid   = {MAX_OPERANDS{commit}} & old_valid_q[head_q];
    assign bus.free_prns    = old_prn_q[head_q];

    // Entry status and pointers; commit clears after completions so a late
    // completion to the retiring head cannot leave a stale done bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                old_valid_q[i] <= '0;
            end
        end else begin
            for (int f = 0; f < FU_COUNT; f++) begin
                if (bus.complete_valid[f] && valid_q[bus.complete_tag[f]]) begin
                    done_q[bus.complete_tag[f]] <= 1'b1;
                end
            end
            if (commit) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (alloc_fire) begin
                valid_q[tail_q]     <= 1'b1;
                done_q[tail_q]      <= 1'b0;
                old_valid_q[tail_q] <= bus.alloc_old_valid;
                tail_q              <= tail_q + 1'b1;
            end
            unique case ({alloc_fire, commit})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // PRN payload only matters while old_valid is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            old_prn_q[tail_q] <= bus.alloc_old_prn;
        end
    end

`ifdef ROB_PERF_COUNT_EN
    // Free-running retirement counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits <= '0;
        end else if (commit) begin
            perf_commits <= perf_commits + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scoreboard bench for reorder_buffer: expected commits are
// queued at allocation and checked when the head retires.
module tb_reorder_buffer;
    localparam int D  = 16;
    localparam int PB = 6;
    localparam int FU = 4;
    localparam int MO = 3;
    localparam int TB = $clog2(D);

    typedef struct packed {
        logic [TB-1:0]          tag;
        logic [MO-1:0]          fv;
        logic [MO-1:0][PB-1:0]  fp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   perf_exp = 0;
    logic [TB-1:0] exp_tail = '0;
    exp_t sb[$];

    reorder_buffer_if #(.ROB_DEPTH(D), .PRN_BITS(PB), .FU_COUNT(FU),
                        .MAX_OPERANDS(MO)) bus ();

`ifdef ROB_PERF_COUNT_EN
    logic [31:0] perf_commits;
    reorder_buffer #(.ROB_DEPTH(D), .PRN_BITS(PB), .FU_COUNT(FU),
                     .MAX_OPERANDS(MO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .perf_commits(perf_commits));
`else
    reorder_buffer #(.ROB_DEPTH(D), .PRN_BITS(PB), .FU_COUNT(FU),
                     .MAX_OPERANDS(MO)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        bus.alloc_valid     = 1'b0;
        bus.alloc_old_valid = '0;
        bus.alloc_old_prn   = '0;
        bus.complete_valid  = '0;
        bus.complete_tag    = '0;
    endtask

    // Check commit expectation for this cycle, then advance to next negedge.
    task automatic step(input logic exp_commit);
        exp_t e;
        #1;
        chk("commit_valid", bus.commit_valid, exp_commit);
        if (bus.commit_valid) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_underflow: observed commit tag %0d expected none",
                       bus.commit_tag);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("commit_tag", bus.commit_tag, e.tag);
                chk("free_valid", bus.free_valid, e.fv);
                for (int i = 0; i < MO; i++) begin
                    if (e.fv[i]) chk("free_prn", bus.free_prns[i], e.fp[i]);
                end
            end
            perf_exp++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alloc(input logic [MO-1:0] ov,
                         input logic [MO-1:0][PB-1:0] op);
        exp_t e;
        bus.alloc_valid     = 1'b1;
        bus.alloc_old_valid = ov;
        bus.alloc_old_prn   = op;
        chk("alloc_ready", bus.alloc_ready, 1'b1);
        chk("alloc_tag", bus.alloc_tag, exp_tail);
        e.tag = exp_tail;
        e.fv  = ov;
        e.fp  = op;
        sb.push_back(e);
        exp_tail = exp_tail + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_tail = '0;
        perf_exp = 0;
    endtask

    task automatic comp(input int port, input int tag);
        bus.complete_valid[port] = 1'b1;
        bus.complete_tag[port]   = TB'(tag);
    endtask

    initial begin
        clear_in();
        @(negedge clk);
        do_reset();
        chk("rst_ready", bus.alloc_ready, 1'b1);
        chk("rst_tag", bus.alloc_tag, 0);
        chk("rst_commit", bus.commit_valid, 1'b0);
        chk("rst_free", bus.free_valid, 0);
        chk("rst_count", bus.count, 0);

        // Three allocations with assorted superseded PRNs
        alloc(3'b001, {6'd0, 6'd0, 6'd33});
        step(1'b0);
        alloc(3'b011, {6'd0, 6'd35, 6'd34});
        step(1'b0);
        alloc(3'b000, '0);
        step(1'b0);
        clear_in();
        chk("count3", bus.count, 3);

        // Out-of-order completion, in-order retirement
        comp(0, 1);
        step(1'b0);
        clear_in();
        comp(1, 0);
        step(1'b0);
        clear_in();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        chk("count1", bus.count, 1);
        comp(2, 2);
        step(1'b0);
        clear_in();
        step(1'b1);
        chk("count0", bus.count, 0);
`ifdef ROB_PERF_COUNT_EN
        chk("perf_mid", perf_commits, perf_exp);
`endif

        // Fill to capacity, blocked alloc, commit and wrap
        do_reset();
        for (int i = 0; i < D; i++) begin
            alloc(3'b100, {PB'(i), 6'd0, 6'd0});
            step(1'b0);
        end
        clear_in();
        chk("full_count", bus.count, D);
        chk("full_ready", bus.alloc_ready, 1'b0);
        bus.alloc_valid     = 1'b1;
        bus.alloc_old_valid = 3'b001;
        bus.alloc_old_prn   = {6'd0, 6'd0, 6'd7};
        step(1'b0);
        chk("full_hold_count", bus.count, D);
        chk("full_hold_tag", bus.alloc_tag, 0);
        comp(0, 0);
        step(1'b0);
        bus.complete_valid = '0;
        step(1'b1);
        chk("after_commit_count", bus.count, D - 1);
        alloc(3'b001, {6'd0, 6'd0, 6'd7});
        step(1'b0);
        clear_in();
        chk("refill_count", bus.count, D);

        // Simultaneous alloc and commit at count 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(3'b010, {6'd0, PB'(10 + i), 6'd0});
            step(1'b0);
        end
        clear_in();
        comp(3, 0);
        step(1'b0);
        clear_in();
        alloc(3'b001, {6'd0, 6'd0, 6'd20});
        step(1'b1);
        clear_in();
        chk("both_count", bus.count, 5);
        chk("both_tail", bus.alloc_tag, 6);

        // Duplicate completions plus completion to an unallocated tag
        comp(0, 1);
        comp(1, 1);
        comp(2, 9);
        step(1'b0);
        clear_in();
        step(1'b1);
        step(1'b0);
        chk("dup_count", bus.count, 4);
        for (int i = 0; i < 4; i++) begin
            alloc(3'b000, '0);
            step(1'b0);
        end
        clear_in();
        chk("dup_count8", bus.count, 8);
        comp(0, 2);
        comp(1, 3);
        comp(2, 4);
        comp(3, 5);
        step(1'b0);
        clear_in();
        comp(0, 6);
        comp(1, 7);
        comp(2, 8);
        step(1'b1);
        clear_in();
        for (int i = 0; i < 6; i++) step(1'b1);
        step(1'b0);
        chk("spurious_count", bus.count, 1);
        chk("spurious_head", bus.commit_tag, 9);

        // Reset with entries in flight, racing alloc and completion
        for (int i = 0; i < 3; i++) begin
            alloc(3'b111, {6'd1, 6'd2, 6'd3});
            step(1'b0);
        end
        clear_in();
        chk("inflight_count", bus.count, 4);
`ifdef ROB_PERF_COUNT_EN
        chk("perf_pre_rst", perf_commits, perf_exp);
`endif
        rst = 1'b1;
        bus.alloc_valid = 1'b1;
        comp(0, 9);
        step(1'b0);
        rst = 1'b0;
        clear_in();
        sb.delete();
        exp_tail = '0;
        perf_exp = 0;
        chk("rst2_count", bus.count, 0);
        chk("rst2_commit", bus.commit_valid, 1'b0);
        chk("rst2_free", bus.free_valid, 0);
        chk("rst2_ready", bus.alloc_ready, 1'b1);
        chk("rst2_tag", bus.alloc_tag, 0);
`ifdef ROB_PERF_COUNT_EN
        chk("rst2_perf", perf_commits, 0);
`endif
        step(1'b0);
        chk("rst2_idle_count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
